// File: rtl/neopixel_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 serializer.
package neopixel_pkg;

    localparam int PIXEL_W    = 24;
    localparam int BITCNT_W   = 5;
    localparam int T0H_DEF    = 20;
    localparam int T1H_DEF    = 40;
    localparam int TBIT_DEF   = 63;
    localparam int TRESET_DEF = 2500;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP,
        ST_LATCH
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neopixel_pixel_skid.sv
// One-entry holding register between the pixel stream and the serializer.
module neopixel_pixel_skid
    import neopixel_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PIXEL_W-1:0] i_data,
    input  logic               i_last,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_pop,
    output logic [PIXEL_W-1:0] o_data,
    output logic               o_last,
    output logic               o_full
);

    logic               r_full;
    logic [PIXEL_W-1:0] r_data;
    logic               r_last;

    // Push only when empty and pop only when full, so the two never coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = !r_full;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_full  = r_full;

endmodule

// File: rtl/neopixel_ws2812_tx.sv
// WS2812 one-wire serializer: holding register, bit shifter and timing FSM.
// Optional sticky underrun flag is built when NEOPIXEL_UNDERRUN_EN is defined.
module neopixel_ws2812_tx
    import neopixel_pkg::*;
#(
    parameter int T0H_CYC    = T0H_DEF,
    parameter int T1H_CYC    = T1H_DEF,
    parameter int TBIT_CYC   = TBIT_DEF,
    parameter int TRESET_CYC = TRESET_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_last,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               neopixel_one_wire,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun,
    input  logic               underrun_clr
);

    localparam int CNT_W = $clog2(max_int(TBIT_CYC, TRESET_CYC) + 1);
    localparam logic [CNT_W-1:0]    L_T0H_M1   = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0]    L_T1H_M1   = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0]    L_T0L_M1   = CNT_W'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CNT_W-1:0]    L_T1L_M1   = CNT_W'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CNT_W-1:0]    L_TRST_M1  = CNT_W'(TRESET_CYC - 1);
    localparam logic [BITCNT_W-1:0] L_LAST_BIT = BITCNT_W'(PIXEL_W - 1);

    generate
        if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRESET_CYC >= 1)) begin : g_bad_params
            $error("neopixel_ws2812_tx: illegal timing parameters");
        end
    endgenerate

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PIXEL_W-1:0]  r_shift;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic                r_last;
    logic                r_line;
    logic                r_frame_done;

    logic               w_full;
    logic [PIXEL_W-1:0] w_hold_data;
    logic               w_hold_last;
    logic               w_pop;
    logic [CNT_W-1:0]   w_hi_m1;
    logic [CNT_W-1:0]   w_lo_m1;
    logic               w_bit_done;
    logic               w_pix_done;

    neopixel_pixel_skid u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (pixel_data),
        .i_last  (pixel_last),
        .i_valid (pixel_valid),
        .o_ready (pixel_ready),
        .i_pop   (w_pop),
        .o_data  (w_hold_data),
        .o_last  (w_hold_last),
        .o_full  (w_full)
    );

    assign w_hi_m1    = r_shift[PIXEL_W-1] ? L_T1H_M1 : L_T0H_M1;
    assign w_lo_m1    = r_shift[PIXEL_W-1] ? L_T1L_M1 : L_T0L_M1;
    assign w_bit_done = (r_state == ST_LOW) && (r_cnt == w_lo_m1);
    assign w_pix_done = w_bit_done && (r_bitcnt == L_LAST_BIT);
    // Loading the next pixel on the final LOW cycle keeps a frame gapless.
    assign w_pop      = w_full && ((r_state == ST_IDLE) || (r_state == ST_GAP) ||
                                   (w_pix_done && !r_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_last       <= 1'b0;
            r_line       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_line       <= (r_state == ST_HIGH);
            r_frame_done <= 1'b0;
            if (w_pop) begin
                r_shift  <= w_hold_data;
                r_last   <= w_hold_last;
                r_bitcnt <= '0;
                r_cnt    <= '0;
                r_state  <= ST_HIGH;
            end else begin
                case (r_state)
                    ST_HIGH: begin
                        if (r_cnt == w_hi_m1) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOW;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (!w_bit_done) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_cnt <= '0;
                            if (!w_pix_done) begin
                                r_shift  <= {r_shift[PIXEL_W-2:0], 1'b0};
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_state  <= ST_HIGH;
                            end else if (r_last) begin
                                r_state <= ST_LATCH;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    end
                    ST_LATCH: begin
                        if (r_cnt == L_TRST_M1) begin
                            r_cnt        <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    assign neopixel_one_wire = r_line;
    assign frame_done        = r_frame_done;
    assign busy              = (r_state != ST_IDLE) || w_full;

`ifdef NEOPIXEL_UNDERRUN_EN
    logic r_underrun;
    logic w_gap_entry;

    assign w_gap_entry = w_pix_done && !r_last && !w_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_gap_entry) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun = r_underrun;
`else
    logic w_unused_clr;
    assign w_unused_clr = underrun_clr;
    assign underrun     = 1'b0;
`endif

endmodule

// File: tb/tb_neopixel_ws2812_tx.sv
// Directed, table-driven bench for neopixel_ws2812_tx at default timing.
module tb_neopixel_ws2812_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_last = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        neopixel_one_wire;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        underrun_clr = 1'b0;

`ifdef NEOPIXEL_UNDERRUN_EN
    localparam int UR_EN = 1;
`else
    localparam int UR_EN = 0;
`endif

    neopixel_ws2812_tx dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pixel_data        (pixel_data),
        .pixel_last        (pixel_last),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .neopixel_one_wire (neopixel_one_wire),
        .busy              (busy),
        .frame_done        (frame_done),
        .underrun          (underrun),
        .underrun_clr      (underrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          exp_hi_msb;
        int          exp_hi_lsb;
        int          exp_ones;
    } vec_t;

    vec_t vec [6];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_arr [4];

    // Line monitor: rise cycle and high length of every pulse, frame_done cycles.
    int   cyc = 0;
    int   hi_cnt = 0;
    logic prev_line = 1'b0;
    int   rise_q [$];
    int   high_q [$];
    int   fd_q [$];
    int   fd_busy_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (neopixel_one_wire && !prev_line) begin
            rise_q.push_back(cyc);
            hi_cnt = 1;
        end else if (neopixel_one_wire) begin
            hi_cnt = hi_cnt + 1;
        end
        if (!neopixel_one_wire && prev_line) high_q.push_back(hi_cnt);
        if (frame_done) begin
            fd_q.push_back(cyc);
            fd_busy_q.push_back(int'(busy));
        end
        prev_line = neopixel_one_wire;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        rise_q.delete();
        high_q.delete();
        fd_q.delete();
        fd_busy_q.delete();
    endtask

    task automatic send(input logic [23:0] d, input logic l, output int hs, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        pixel_data  = d;
        pixel_last  = l;
        pixel_valid = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            ok = pixel_ready;
            @(posedge clk);
            if (ok) break;
            #1;
            waited++;
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        hs = cyc;
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic wait_frame_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("frame_done_timeout", 0, 1);
        @(negedge clk);
        #1;
    endtask

    // gap = 0: offer pixels back to back; gap > 0: hold each follower until its predecessor has run dry.
    task automatic run_frame(input int first, input int n, input int gap);
        int w;
        clear_mon();
        for (int p = 0; p < n; p++) begin
            if (gap > 0 && p > 0) begin
                repeat (1512 + gap) @(posedge clk);
                #1;
            end
            send(vec[first+p].data, vec[first+p].last, hs_arr[p], w);
            if (gap == 0 && p == 1) begin
                @(negedge clk);
                chk("bp_ready_low", int'(pixel_ready), 0);
                chk("bp_busy", int'(busy), 1);
            end
            if (gap == 0 && p == 2) chk("bp_waited", int'(w > 0), 1);
        end
        wait_frame_done();
    endtask

    task automatic analyze(input int first, input int n, input int gapped);
        int ones;
        int last_rise;
        chk("nbits", high_q.size(), 24 * n);
        chk("nrises", rise_q.size(), 24 * n);
        if (high_q.size() != 24 * n || rise_q.size() != 24 * n) return;
        chk("first_rise_latency", rise_q[0] - hs_arr[0], 3);
        for (int p = 0; p < n; p++) begin
            ones = 0;
            for (int b = 0; b < 24; b++) begin
                chk("bit_high", high_q[24*p+b], vec[first+p].data[23-b] ? 40 : 20);
                if (high_q[24*p+b] == 40) ones++;
                if ((24*p + b) > 0 && !(gapped != 0 && b == 0))
                    chk("bit_period", rise_q[24*p+b] - rise_q[24*p+b-1], 63);
            end
            chk("pix_hi_msb", high_q[24*p], vec[first+p].exp_hi_msb);
            chk("pix_hi_lsb", high_q[24*p+23], vec[first+p].exp_hi_lsb);
            chk("pix_ones", ones, vec[first+p].exp_ones);
        end
        if (gapped != 0) chk("resume_latency", rise_q[24] - hs_arr[1], 3);
        chk("frame_done_count", fd_q.size(), 1);
        if (fd_q.size() == 1) begin
            last_rise = rise_q[24*n-1];
            // Last bit period (63) plus latch (2500), minus the one-cycle line register lag.
            chk("frame_done_offset", fd_q[0] - last_rise, 62 + 2500);
            chk("busy_at_frame_done", fd_busy_q[0], 0);
        end
        chk("frame_done_after", int'(frame_done), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = '{24'hA50000, 1'b1, 40, 20, 4};
        vec[1] = '{24'hFFFFFF, 1'b0, 40, 40, 24};
        vec[2] = '{24'h000000, 1'b0, 20, 20, 0};
        vec[3] = '{24'h800001, 1'b1, 40, 40, 2};
        vec[4] = '{24'h00FF00, 1'b0, 20, 20, 8};
        vec[5] = '{24'h0000FF, 1'b1, 20, 40, 8};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_line", int'(neopixel_one_wire), 0);
        chk("rst_ready", int'(pixel_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel, then back-to-back frame with backpressure on the third pixel
        run_frame(0, 1, 0);
        analyze(0, 1, 0);
        run_frame(1, 3, 0);
        analyze(1, 3, 0);
        chk("bp_accept_cycle", hs_arr[2] - hs_arr[0], 1514);
        chk("b2b_underrun", int'(underrun), 0);

        // Underrun: second pixel arrives 200 cycles after the first has finished
        run_frame(4, 2, 200);
        analyze(4, 2, 1);
        chk("underrun_set", int'(underrun), UR_EN);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("underrun_cleared", int'(underrun), 0);

        // Asynchronous reset during a HIGH phase
        begin
            int   hs;
            int   w;
            logic seen;
            seen = 1'b0;
            send(24'hFFFFFF, 1'b1, hs, w);
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (neopixel_one_wire) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("async_line_high_seen", int'(seen), 1);
            repeat (5) @(negedge clk);
            #2;
            reset_n = 1'b0;
            #1;
            chk("async_line_low", int'(neopixel_one_wire), 0);
            chk("async_ready", int'(pixel_ready), 1);
            chk("async_busy", int'(busy), 0);
            @(negedge clk);
            reset_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_line", int'(neopixel_one_wire), 0);
        end
        run_frame(3, 1, 0);
        analyze(3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neopixel_ws2812_tx.md
# neopixel_ws2812_tx

- Serializes 24-bit GRB pixels into the WS2812 one-wire waveform.
- Drives the `neopixel_one_wire` export of the SoC top level.
- Sits directly downstream of the HPS-facing pixel buffer: it consumes a valid/ready pixel stream and emits the timed bit pattern, followed by the latch (reset) low period at frame end.

## Interface
Parameters:
- T0H_CYC, 20, high time of a 0 bit in clk cycles (400 ns @ 50 MHz)
- T1H_CYC, 40, high time of a 1 bit (800 ns)
- TBIT_CYC, 63, full bit period (1.26 µs)
- TRESET_CYC, 2500, latch low time after last pixel (50 µs)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pixel_data  in  24  {G[7:0],R[7:0],B[7:0]}, transmitted MSB first
- pixel_last  in  1  pixel is the final one of a frame
- pixel_valid  in  1  pixel_data/pixel_last valid
- pixel_ready  out  1  block accepts the pixel this cycle
- neopixel_one_wire  out  1  registered serial output to the LED chain
- busy  out  1  frame in progress or pixel pending
- frame_done  out  1  one-cycle pulse at end of latch period
- underrun  out  1  sticky mid-frame starvation flag
- underrun_clr  in  1  clears underrun

Reset values: neopixel_one_wire=0, pixel_ready=1, busy=0, frame_done=0, underrun=0.

## Operation
- **Holding register:** one entry holds {data, last}.
  - pixel_ready = holding empty.
  - A handshake occurs when valid&ready.
  - Upstream holds data stable while valid&!ready.
- **Shifter:** 24-bit shift register plus a 5-bit bit counter.
- **FSM states:** IDLE, HIGH, LOW, GAP, LATCH.
  - IDLE: line low. If holding is full, load the shifter, free the holding register, and go to HIGH.
  - HIGH: line high for T0H_CYC or T1H_CYC cycles, per the current MSB; then go to LOW.
  - LOW: line low until the bit period totals TBIT_CYC cycles.
    - If bits remain: shift left, go to HIGH.
    - Pixel done and its last=1: go to LATCH.
    - Pixel done, last=0, holding full: load the shifter the same cycle, go to HIGH (no gap).
    - Pixel done, last=0, holding empty: go to GAP.
  - GAP: line low. When holding becomes full, load it and go to HIGH.
  - LATCH: line low for TRESET_CYC cycles, then pulse frame_done and go to IDLE. Holding may fill during LATCH; its transmission starts only after LATCH ends.
- **busy:** 1 when state≠IDLE or holding is full.
- **Counters:** one cycle counter, width $clog2(max(TBIT_CYC,TRESET_CYC)+1), cleared on every state entry. No wrap is possible within legal parameters.
- **Parameter legality:** 0 < T0H_CYC < T1H_CYC < TBIT_CYC and TRESET_CYC ≥ 1. Enforce with elaboration-time assertions.
- **underrun:** set on entry to GAP. underrun_clr clears it; if clear and set occur in the same cycle, set wins.
- **Reset mid-operation:** reset_n low forces line low asynchronously. It also discards the holding and shifter contents and returns the FSM to IDLE.

## Timing
- From a handshake while IDLE with holding empty:
  - holding loads at edge N;
  - shifter loads and the state enters HIGH at edge N+1;
  - neopixel_one_wire rises at edge N+2.
- Consecutive pixels in a frame are contiguous when each is accepted before its predecessor's final LOW cycle. The line then runs 24·TBIT_CYC cycles per pixel with no extra cycles.
- frame_done asserts for exactly one cycle, TRESET_CYC cycles after the last bit period ends. busy falls in the same cycle unless holding is full.
- pixel_ready rises the cycle after the holding register transfers into the shifter.

## Configuration
- Macro NEOPIXEL_UNDERRUN_EN.
  - Defined: sticky underrun flag and underrun_clr are implemented as above.
  - Undefined: underrun is tied to 0 and underrun_clr is ignored. GAP behaviour is unchanged.

## Structure
- Shared package neopixel_pkg holds:
  - the state enum type;
  - PIXEL_W=24;
  - default timing constants for a 50 MHz clk.
- Natural sub-module: neopixel_pixel_skid, the one-entry holding register carrying the valid/ready handshake.
- The FSM, counters and shifter stay in neopixel_ws2812_tx.

## Test plan
All scenarios use default parameters.
- **Reset:** assert reset_n=0 → line 0, ready 1, busy 0, frame_done 0, underrun 0.
- **Single pixel:** 0xA50000 with last=1 →
  - bit0 high 40 cycles, bit1 high 20 cycles, each bit 63 cycles;
  - 1512 cycles of data, then 2500 low;
  - frame_done one-cycle pulse, busy falls.
- **Back-to-back frame:** 0xFFFFFF, 0x000000, 0x800001(last) offered continuously → 72 contiguous bit periods, every 63 cycles, then latch.
- **Underrun:** 0x00FF00 (last=0), second pixel delayed 200 cycles → line low through the gap, underrun=1, transmission resumes; underrun_clr returns the flag to 0.
- **Backpressure:** third pixel presented during pixel 1's transmission (holding full, since pixel 2 is already queued) → pixel_ready=0, data held, accepted the cycle after pixel 2 loads.
- **Async reset mid-frame:** reset_n=0 during a HIGH phase → line falls without waiting for clk. After release the block is idle and a new frame transmits correctly.
